// File: rtl/led7_scan_if.sv
// Display driver bus: packed digit value, dp requests and glyph controls in,
// active-low anode/segment/dp pins out.
interface led7_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] i_w_value;
  logic [DIGITS-1:0]   i_w_dp;
  logic                i_w_load;
  logic                i_w_hex;
  logic                i_w_lzb;
  logic [DIGITS-1:0]   o_w_anode;
  logic [6:0]          o_w_seg;
  logic                o_w_dp;

  modport master (
    output i_w_value, i_w_dp, i_w_load, i_w_hex, i_w_lzb,
    input  o_w_anode, o_w_seg, o_w_dp
  );

  modport slave (
    input  i_w_value, i_w_dp, i_w_load, i_w_hex, i_w_lzb,
    output o_w_anode, o_w_seg, o_w_dp
  );
endinterface

// File: rtl/led7_scan.sv
// Time-multiplexed common-anode 7-segment driver: scans one digit per PRESCALE
// cycles from shadow registers, with a GUARD blanking window at each slot start.
module led7_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned GUARD    = 1
) (
  input  logic          i_w_clk,
  input  logic          i_w_reset,
  led7_scan_if.slave    bus
);
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_anode;
  logic [6:0]          r_seg;
  logic                r_dp_n;

  logic                w_wrap;
  logic                w_lit;
  logic [3:0]          w_nib;
  logic                w_dp_sel;
  logic                w_blank;
  logic [DIGITS-1:0]   w_anode;
  logic [6:0]          w_seg;

  function automatic logic [6:0] f_glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0011000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (!hex && (nib > 4'd9)) g = 7'h7F;
    return g;
  endfunction

  assign w_wrap = (r_cnt == CW'(PRESCALE - 1));

  // Anodes stay dark for the first GUARD cycles of every slot to hide ghosting.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_lit = 1'b1;
    end else begin : g_guard
      assign w_lit = (r_cnt >= CW'(GUARD));
    end
  endgenerate

  always_comb begin
    w_nib    = 4'd0;
    w_dp_sel = 1'b0;
    w_blank  = 1'b0;
    w_anode  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib    = r_value[4*k +: 4];
        w_dp_sel = r_dp[k];
        w_blank  = bus.i_w_lzb && (k != 0) && ((r_value >> (4*k)) == '0);
        if (w_lit) w_anode[k] = 1'b0;
      end
    end
    w_seg = w_blank ? 7'h7F : f_glyph(w_nib, bus.i_w_hex);
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_value <= '0;
      r_dp    <= '0;
      r_anode <= '1;
      r_seg   <= 7'h7F;
      r_dp_n  <= 1'b1;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        if (r_idx == IW'(DIGITS - 1)) r_idx <= '0;
        else                          r_idx <= r_idx + IW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (bus.i_w_load) begin
        r_value <= bus.i_w_value;
        r_dp    <= bus.i_w_dp;
      end
      r_anode <= w_anode;
      r_seg   <= w_seg;
      r_dp_n  <= ~w_dp_sel;
    end
  end

  assign bus.o_w_anode = r_anode;
  assign bus.o_w_seg   = r_seg;
  assign bus.o_w_dp    = r_dp_n;
endmodule

// File: tb/tb_led7_scan.sv
// Randomised self-checking bench for led7_scan: 4-digit/PRESCALE 4/GUARD 1 main
// instance against a cycle-count reference model, plus a 1-digit GUARD 0 instance.
module tb_led7_scan;
  localparam int unsigned D = 4;
  localparam int unsigned P = 4;
  localparam int unsigned G = 1;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [3:0] ANODE_SEQ [16] = '{
    4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
    4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7
  };

  logic clk = 1'b0;
  logic rst;
  logic rst_b;

  led7_scan_if #(.DIGITS(4)) bus_a ();
  led7_scan_if #(.DIGITS(1)) bus_b ();

  led7_scan #(.DIGITS(4), .PRESCALE(4), .GUARD(1)) dut_a (
    .i_w_clk(clk), .i_w_reset(rst), .bus(bus_a.slave)
  );
  led7_scan #(.DIGITS(1), .PRESCALE(4), .GUARD(0)) dut_b (
    .i_w_clk(clk), .i_w_reset(rst_b), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: edges since reset release plus the shadow contents.
  int          m_n;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_dp;

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int idx,
                                         input logic hex, input logic lzb);
    logic [15:0] sh;
    int nib;
    sh  = v >> (4*idx);
    nib = int'(sh[3:0]);
    if (lzb && idx > 0 && sh == 16'd0) return 7'h7F;
    if (!hex && nib >= 10) return 7'h7F;
    return GLYPH[nib];
  endfunction

  // Predict the outputs for the coming edge, then advance model and clock.
  task automatic tick();
    int c, idx;
    c   = m_n % int'(P);
    idx = (m_n / int'(P)) % int'(D);
    e_anode = (c >= int'(G)) ? ~(4'b0001 << idx) : 4'hF;
    e_seg   = ref_seg(m_val, idx, bus_a.i_w_hex, bus_a.i_w_lzb);
    e_dp    = ~m_dp[idx];
    @(posedge clk);
    if (bus_a.i_w_load) begin
      m_val = bus_a.i_w_value;
      m_dp  = bus_a.i_w_dp;
    end
    m_n++;
    #1;
  endtask

  task automatic model_reset();
    m_n = 0; m_val = 16'd0; m_dp = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.i_w_value = 16'd0; bus_a.i_w_dp = 4'd0; bus_a.i_w_load = 1'b0;
    bus_a.i_w_hex = 1'b0;    bus_a.i_w_lzb = 1'b0;
    #1;
    n_total++;
    if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {4'hF, 7'h7F, 1'b1})
      $display("FAIL reset got %b/%b/%b want 1111/1111111/1",
               bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_scan_timing();
    for (int i = 0; i < 18; i++) begin
      tick();
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {e_anode, e_seg, e_dp})
        $display("FAIL scan_model[%0d] got %b/%b/%b want %b/%b/%b", i, bus_a.o_w_anode,
                 bus_a.o_w_seg, bus_a.o_w_dp, e_anode, e_seg, e_dp);
      else n_pass++;
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg} !== {ANODE_SEQ[i % 16], 7'b1000000})
        $display("FAIL scan_seq[%0d] got %b/%b want %b/1000000", i,
                 bus_a.o_w_anode, bus_a.o_w_seg, ANODE_SEQ[i % 16]);
      else n_pass++;
    end
  endtask

  task automatic test_glyph_modes();
    for (int i = 0; i < 34; i++) begin
      bus_a.i_w_load = (i == 0);
      if (i == 0) begin bus_a.i_w_value = 16'h12A5; bus_a.i_w_hex = 1'b1; end
      if (i == 18) bus_a.i_w_hex = 1'b0;
      tick();
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {e_anode, e_seg, e_dp})
        $display("FAIL glyph[%0d] got %b/%b/%b want %b/%b/%b", i, bus_a.o_w_anode,
                 bus_a.o_w_seg, bus_a.o_w_dp, e_anode, e_seg, e_dp);
      else n_pass++;
    end
    bus_a.i_w_load = 1'b0;
  endtask

  task automatic test_lzb_dp();
    bus_a.i_w_lzb = 1'b1;
    bus_a.i_w_hex = 1'b1;
    for (int i = 0; i < 54; i++) begin
      bus_a.i_w_load = (i == 0) || (i == 18) || (i == 36);
      if (i == 0)  bus_a.i_w_value = 16'h0070;
      if (i == 18) bus_a.i_w_value = 16'h0000;
      if (i == 36) bus_a.i_w_dp    = 4'b0100;
      tick();
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {e_anode, e_seg, e_dp})
        $display("FAIL lzb_dp[%0d] got %b/%b/%b want %b/%b/%b", i, bus_a.o_w_anode,
                 bus_a.o_w_seg, bus_a.o_w_dp, e_anode, e_seg, e_dp);
      else n_pass++;
    end
    bus_a.i_w_load = 1'b0;
  endtask

  task automatic test_load_hold();
    bus_a.i_w_lzb = 1'b0;
    bus_a.i_w_value = 16'h8888;
    bus_a.i_w_dp = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {e_anode, e_seg, e_dp})
        $display("FAIL hold[%0d] got %b/%b/%b want %b/%b/%b", i, bus_a.o_w_anode,
                 bus_a.o_w_seg, bus_a.o_w_dp, e_anode, e_seg, e_dp);
      else n_pass++;
    end
    while ((m_n % int'(P)) != 2) tick();
    for (int i = 0; i < 10; i++) begin
      bus_a.i_w_load = (i == 0);
      tick();
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {e_anode, e_seg, e_dp})
        $display("FAIL midslot_load[%0d] got %b/%b/%b want %b/%b/%b", i, bus_a.o_w_anode,
                 bus_a.o_w_seg, bus_a.o_w_dp, e_anode, e_seg, e_dp);
      else n_pass++;
    end
    bus_a.i_w_load = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      bus_a.i_w_value = 16'($urandom);
      bus_a.i_w_dp    = 4'($urandom);
      bus_a.i_w_load  = ($urandom_range(0, 3) == 0);
      bus_a.i_w_hex   = 1'($urandom);
      bus_a.i_w_lzb   = 1'($urandom);
      if ($urandom_range(0, 2) == 0) bus_a.i_w_value[15:8] = 8'h00;
      tick();
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {e_anode, e_seg, e_dp})
        $display("FAIL random[%0d] got %b/%b/%b want %b/%b/%b", i, bus_a.o_w_anode,
                 bus_a.o_w_seg, bus_a.o_w_dp, e_anode, e_seg, e_dp);
      else n_pass++;
    end
    bus_a.i_w_load = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    bus_a.i_w_value = 16'h4321; bus_a.i_w_dp = 4'b0100; bus_a.i_w_load = 1'b1;
    tick();
    bus_a.i_w_load = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      found = (e_anode == 4'b1011);
    end
    n_total++;
    if (!found || bus_a.o_w_anode !== 4'b1011)
      $display("FAIL reach_digit2 got anode %b want 1011", bus_a.o_w_anode);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {4'hF, 7'h7F, 1'b1})
      $display("FAIL async_reset got %b/%b/%b want 1111/1111111/1",
               bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if ({bus_a.o_w_anode, bus_a.o_w_seg, bus_a.o_w_dp} !== {e_anode, e_seg, e_dp} ||
          bus_a.o_w_anode !== ANODE_SEQ[i])
        $display("FAIL restart[%0d] got %b/%b/%b want %b/%b/%b", i, bus_a.o_w_anode,
                 bus_a.o_w_seg, bus_a.o_w_dp, e_anode, e_seg, e_dp);
      else n_pass++;
    end
  endtask

  task automatic test_single_digit();
    logic [3:0] v;
    logic [6:0] want_seg;
    logic       want_dp;
    v = 4'($urandom_range(1, 15));
    n_total++;
    if ({bus_b.o_w_anode, bus_b.o_w_seg, bus_b.o_w_dp} !== {1'b1, 7'h7F, 1'b1})
      $display("FAIL d1_reset got %b/%b/%b want 1/1111111/1",
               bus_b.o_w_anode, bus_b.o_w_seg, bus_b.o_w_dp);
    else n_pass++;
    @(negedge clk);
    rst_b = 1'b0;
    bus_b.i_w_value = v; bus_b.i_w_dp = 1'b1; bus_b.i_w_load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      bus_b.i_w_load = 1'b0;
      want_seg = (i == 0) ? GLYPH[0] : GLYPH[v];
      want_dp  = (i == 0);
      n_total++;
      if ({bus_b.o_w_anode, bus_b.o_w_seg, bus_b.o_w_dp} !== {1'b0, want_seg, want_dp})
        $display("FAIL d1_scan[%0d] got %b/%b/%b want 0/%b/%b", i, bus_b.o_w_anode,
                 bus_b.o_w_seg, bus_b.o_w_dp, want_seg, want_dp);
      else n_pass++;
    end
    #2 rst_b = 1'b1;
    #1;
    n_total++;
    if ({bus_b.o_w_anode, bus_b.o_w_seg, bus_b.o_w_dp} !== {1'b1, 7'h7F, 1'b1})
      $display("FAIL d1_async_reset got %b/%b/%b want 1/1111111/1",
               bus_b.o_w_anode, bus_b.o_w_seg, bus_b.o_w_dp);
    else n_pass++;
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({bus_b.o_w_anode, bus_b.o_w_seg, bus_b.o_w_dp} !== {1'b0, GLYPH[0], 1'b1})
      $display("FAIL d1_restart got %b/%b/%b want 0/%b/1",
               bus_b.o_w_anode, bus_b.o_w_seg, bus_b.o_w_dp, GLYPH[0]);
    else n_pass++;
  endtask

  initial begin
    rst_b = 1'b1;
    bus_b.i_w_value = 4'd0; bus_b.i_w_dp = 1'b0; bus_b.i_w_load = 1'b0;
    bus_b.i_w_hex = 1'b1;   bus_b.i_w_lzb = 1'b1;
    test_reset();
    test_scan_timing();
    test_glyph_modes();
    test_lzb_dp();
    test_load_hold();
    test_random();
    test_async_reset();
    test_single_digit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish by 100000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/led7_scan.md
Name: led7_scan

Overview:
- Parametrised, time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Holds a shadow copy of a packed BCD/hex value and scans one digit at a time at a prescaled rate.
- Drives active-low anodes, segments and decimal point; supports hex/decimal glyph mode, leading-zero blanking and an anti-ghosting guard interval.
- Sits between datapath/debug registers and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned (>=1).
- PRESCALE, 1000, clock cycles per digit slot (>=2).
- GUARD, 1, cycles at the start of each slot with all anodes off (0 <= GUARD < PRESCALE).

Ports:
- i_w_clk  input  1  system clock; all state changes on the rising edge.
- i_w_reset  input  1  asynchronous, active-high reset.
- i_w_value  input  4*DIGITS  packed nibbles; digit k = bits [4k+3:4k]; digit 0 = least significant, rightmost.
- i_w_dp  input  DIGITS  decimal-point request per digit, active high.
- i_w_load  input  1  when high at a clock edge, shadow value and dp registers capture i_w_value and i_w_dp.
- i_w_hex  input  1  1 = hex glyphs for 10..15; 0 = decimal, where 10..15 are blank.
- i_w_lzb  input  1  1 = leading-zero blanking enabled.
- o_w_anode  output  DIGITS  active-low digit enables; at most one bit low at any time.
- o_w_seg  output  7  active-low segments; bit6 = g ... bit0 = a.
- o_w_dp  output  1  active-low decimal point.

Behaviour:
- Reset (asynchronous, active-high):
  - prescale counter = 0; digit index = 0; shadow value = 0; shadow dp = 0.
  - o_w_anode = all ones, o_w_seg = 7'h7F, o_w_dp = 1.
- Prescale counter:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - On the wrap edge, the digit index advances by one, wrapping from DIGITS-1 to 0.
- Output registers: outputs are registered, one cycle of latency from counter/index state.
  - At the edge where the counter goes from c to c+1 (or wraps), the outputs take the values computed from the pre-edge counter and index.
  - Anode for the current index is driven low only when the pre-edge counter >= GUARD; otherwise all anodes are high.
  - o_w_seg and o_w_dp are updated every cycle from the current index, independent of the guard interval.
- Glyph table (active low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0011000
  - hex only: A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - blank = 1111111.
- Decimal mode: nibbles 10..15 decode to blank.
- Leading-zero blanking (i_w_lzb = 1):
  - Digit k > 0 is blank if its nibble and every more-significant nibble are zero.
  - Digit 0 is never blanked by this rule.
  - Blanking affects segments only. o_w_dp = ~shadow_dp[index], regardless of blanking.
- Shadow load:
  - The display always decodes shadow registers, never i_w_value directly.
  - A load takes effect on segments one cycle after capture (two edges after i_w_load is sampled).
  - Loading mid-slot is legal and changes the glyph without disturbing the scan timing.
- i_w_hex and i_w_lzb are sampled live each cycle and are not shadowed.
- DIGITS = 1: the index stays 0, and the anode is a single bit gated only by the guard interval.
- Reset asserted mid-scan: all outputs return to reset values immediately (asynchronous); scanning restarts at digit 0, counter 0, on the first edge after release.

Test Plan (DIGITS = 4, PRESCALE = 4, GUARD = 1 unless noted):
- Reset, then idle with value 0, lzb = 0 → cycle pattern is anode 1111 for guard, then 1110 for 3 cycles with seg 1000000; digit 1 (anode 1101) follows at cycles 5-8; index returns to 0 after 16 cycles.
- Load 16'h12A5, hex = 1 → digits 0..3 show 0010010 / 0001000 / 0100100 / 1111001; with hex = 0, digit 1 shows 1111111.
- Load 16'h0070, lzb = 1 → digits 3 and 2 blank, digit 1 = 1111000, digit 0 = 1000000; load 16'h0000 → only digit 0 lit, showing "0".
- dp = 4'b0100 with value 16'h0000, lzb = 1 → digit 2 segments blank but o_w_dp = 0 during its slot; o_w_dp = 1 in all other slots.
- Change i_w_value without i_w_load → no output change; pulse i_w_load mid-slot → new glyph appears after 2 edges, and the slot boundary timing is unchanged.
- Assert reset during digit 2's lit interval → outputs go to 1111/7F/1 without waiting for a clock edge; after release the scan resumes at digit 0. Repeat with GUARD = 0 and DIGITS = 1: anode is low in every cycle after the first edge.
